dma_axi_fault_monitor: RTL and testbench
========================================

// Module: dma_axi_fault_monitor
// PURPOSE
// - Sits between the DMA core's AXI master port and the IOMMU-facing AXI_BUS_MMU interconnect.
// - Passes all traffic through with zero cycles of added latency.
// - Caps outstanding reads and writes separately, and records the AR/AW address of every in-flight burst.
// - On an error response (SLVERR/DECERR, e.g. an IOMMU translation fault):
//   - latches fault information;
//   - raises an interrupt;
//   - lets software read the faulting DMA address.
// PARAMETERS
// - MaxRdTxns     default 8     max outstanding AR bursts (power of 2, >=2)
// - MaxWrTxns     default 8     max outstanding AW bursts (power of 2, >=2)
// - AddrWidth     default 64    AXI address width
// - axi_req_t     default logic AXI master request struct, including stream_id/ss_id_valid/substream_id
// - axi_rsp_t     default logic AXI master response struct
// PORTS
// - clk_i          in   1          clock
// - rst_ni         in   1          asynchronous active-low reset
// - slv_req_i      in   axi_req_t  request from DMA backend
// - slv_rsp_o      out  axi_rsp_t  response to DMA backend
// - mst_req_o      out  axi_req_t  request towards IOMMU
// - mst_rsp_i      in   axi_rsp_t  response from IOMMU
// - clear_i        in   1          one-cycle pulse: clear latched fault and counter
// - fault_o        out  1          fault latched; level interrupt
// - fault_addr_o   out  AddrWidth  address of first faulting burst
// - fault_is_wr_o  out  1          first fault was on the write path
// - fault_resp_o   out  2          AXI resp code of first fault
// - fault_unexp_o  out  1          first fault was a response with no tracked burst
// - fault_cnt_o    out  8          saturating count of error responses since clear
// - busy_o         out  1          any read or write burst outstanding
// BEHAVIOUR
// - Reset:
//   - all fault_* outputs and busy_o are 0;
//   - both address FIFOs are empty.
// - Pass-through: all channels are combinational, except the gating below.
// - AR gate (rd_full = read FIFO holds MaxRdTxns entries):
//   - mst_req_o.ar_valid = slv ar_valid & !rd_full;
//   - slv_rsp_o.ar_ready = mst ar_ready & !rd_full.
// - AW gate: identical, using the write FIFO.
// - W, R and B channels are never gated.
// - Push: on each downstream AR (AW) handshake, push ar.addr (aw.addr) into the read (write) FIFO.
// - Pop:
//   - read FIFO pops on an R handshake with r.last;
//   - write FIFO pops on a B handshake.
//   - All traffic uses a single AXI ID, so responses return in order.
// - Push and pop in the same cycle: occupancy unchanged. This is legal even when the FIFO is full.
// - Error: a response is an error when resp[1]==1.
//   - R beats are checked on every beat, but only the last beat's address pop applies.
//   - The first error while fault_o==0 latches fault_addr_o from the FIFO head, plus fault_is_wr_o and fault_resp_o, and sets fault_o on the next cycle.
//   - Errors while fault_o==1 do not overwrite the latched information.
//   - fault_cnt_o += errors this cycle (0..2), saturating at 255.
// - Simultaneous R and B errors while fault_o==0: the read error is latched; count += 2.
// - Unexpected response (R last or B with its FIFO empty):
//   - treated as an error;
//   - latches addr '0 with fault_unexp_o=1;
//   - no pop occurs, so there is no underflow.
// - clear_i: clears fault_o, fault_* and fault_cnt_o on the next cycle.
//   - If clear_i coincides with a new error, the new error wins: it is latched and fault_cnt_o = number of errors this cycle.
// - busy_o = read FIFO not empty | write FIFO not empty (registered occupancy).
// - Reset mid-burst: the FIFOs flush. The bench resets the neighbouring DMA and IOMMU together.
// STRUCTURE
// - Package dma_fault_mon_pkg: fault_info_t {addr, is_wr, resp, unexp}, AXI_RESP_SLVERR/DECERR constants.
// - Sub-module dma_addr_fifo (instanced twice):
//   - in-order address FIFO with push/pop/full/empty/head;
//   - pointer width $clog2(Depth)+1.
// - The top level holds the gating logic, fault latch, and saturating counter.
// TESTING
// - Reset, then 1 AR addr 0x1000 with R len 4, all OKAY -> busy_o 1 until the last beat; fault_o stays 0, fault_cnt_o 0.
// - MaxRdTxns=8: issue 9 ARs with R held off -> 9th ar_ready=0 and mst ar_valid=0. Return 1 R last -> 9th AR accepted in the same cycle.
// - AWs 0x2000, 0x3000; B OKAY then B SLVERR -> fault_o=1, fault_addr_o=0x3000, fault_is_wr_o=1, fault_resp_o=2, fault_cnt_o=1.
// - R DECERR (addr 0x4000) and B SLVERR in the same cycle -> fault_is_wr_o=0, fault_addr_o=0x4000, fault_resp_o=3, fault_cnt_o=2.
// - clear_i coinciding with a new B DECERR -> fault_o stays 1, new info latched, fault_cnt_o=1; 300 further errors -> fault_cnt_o=255.
// - B with an empty write FIFO -> fault_unexp_o=1, fault_addr_o=0, no FIFO underflow. Assert rst_ni mid-burst -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/dma_fault_mon_pkg.sv
// Shared AXI channel structs, response codes and fault record for the DMA fault monitor.
package dma_fault_mon_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam int AXI_ADDR_W  = 64;
  localparam int AXI_ID_W    = 4;
  localparam int AXI_DATA_W  = 64;
  localparam int STREAM_ID_W = 24;
  localparam int SUBSTRM_W   = 20;

  typedef struct packed {
    logic [AXI_ID_W-1:0]    id;
    logic [AXI_ADDR_W-1:0]  addr;
    logic [7:0]             len;
    logic [2:0]             size;
    logic [1:0]             burst;
    logic [STREAM_ID_W-1:0] stream_id;
    logic                   ss_id_valid;
    logic [SUBSTRM_W-1:0]   substream_id;
  } axi_ax_t;

  typedef struct packed {
    logic [AXI_DATA_W-1:0]   data;
    logic [AXI_DATA_W/8-1:0] strb;
    logic                    last;
  } axi_w_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_DATA_W-1:0] data;
    logic [1:0]            resp;
    logic                  last;
  } axi_r_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0] id;
    logic [1:0]          resp;
  } axi_b_t;

  typedef struct packed {
    axi_ax_t aw;
    logic    aw_valid;
    axi_w_t  w;
    logic    w_valid;
    logic    b_ready;
    axi_ax_t ar;
    logic    ar_valid;
    logic    r_ready;
  } axi_req_t;

  typedef struct packed {
    logic   aw_ready;
    logic   w_ready;
    logic   b_valid;
    axi_b_t b;
    logic   ar_ready;
    logic   r_valid;
    axi_r_t r;
  } axi_rsp_t;

  typedef struct packed {
    logic [AXI_ADDR_W-1:0] addr;
    logic                  is_wr;
    logic [1:0]            resp;
    logic                  unexp;
  } fault_info_t;

endpackage

// File: rtl/dma_addr_fifo.sv
// In-order FIFO holding the start address of every in-flight burst; head is the oldest.
module dma_addr_fifo #(
  parameter int Depth = 8,
  parameter int Width = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [Width-1:0] head_o
);

  // Extra MSB on each pointer distinguishes full from empty.
  localparam int PtrW = $clog2(Depth) + 1;

  logic [PtrW-1:0]  wr_ptr, rd_ptr;
  logic [Width-1:0] mem [Depth];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_i) wr_ptr <= wr_ptr + 1'b1;
      if (pop_i)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem[wr_ptr[PtrW-2:0]] <= data_i;
  end

  assign empty_o = (wr_ptr == rd_ptr);
  assign full_o  = (wr_ptr[PtrW-1] != rd_ptr[PtrW-1]) &&
                   (wr_ptr[PtrW-2:0] == rd_ptr[PtrW-2:0]);
  assign head_o  = mem[rd_ptr[PtrW-2:0]];

endmodule

// File: rtl/dma_axi_fault_monitor.sv
// Zero-latency AXI pass-through that caps outstanding bursts and latches the first error response.
module dma_axi_fault_monitor
  import dma_fault_mon_pkg::*;
#(
  parameter int  MaxRdTxns = 8,
  parameter int  MaxWrTxns = 8,
  parameter int  AddrWidth = 64,
  parameter type axi_req_t = dma_fault_mon_pkg::axi_req_t,
  parameter type axi_rsp_t = dma_fault_mon_pkg::axi_rsp_t
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  axi_req_t             slv_req_i,
  output axi_rsp_t             slv_rsp_o,
  output axi_req_t             mst_req_o,
  input  axi_rsp_t             mst_rsp_i,
  input  logic                 clear_i,
  output logic                 fault_o,
  output logic [AddrWidth-1:0] fault_addr_o,
  output logic                 fault_is_wr_o,
  output logic [1:0]           fault_resp_o,
  output logic                 fault_unexp_o,
  output logic [7:0]           fault_cnt_o,
  output logic                 busy_o
);

  // Handshakes: a beat transfers in a cycle where valid and ready are both high;
  // valid never waits on ready, and only AR/AW valid+ready are masked when a FIFO is full.

  logic                 rd_full, rd_empty, rd_push, rd_pop, rd_gate;
  logic                 wr_full, wr_empty, wr_push, wr_pop, wr_gate;
  logic [AddrWidth-1:0] rd_head, wr_head;
  logic                 r_hs, r_last_hs, b_hs, rd_err, wr_err;

  assign r_hs      = mst_rsp_i.r_valid & slv_req_i.r_ready;
  assign r_last_hs = r_hs & mst_rsp_i.r.last;
  assign b_hs      = mst_rsp_i.b_valid & slv_req_i.b_ready;

  // A last beat / B with nothing tracked never pops, so pointers cannot underflow.
  assign rd_pop = r_last_hs & ~rd_empty;
  assign wr_pop = b_hs & ~wr_empty;

  // A full FIFO still accepts a new burst in the cycle its head retires.
  assign rd_gate = rd_full & ~rd_pop;
  assign wr_gate = wr_full & ~wr_pop;

  always_comb begin
    mst_req_o          = slv_req_i;
    mst_req_o.ar_valid = slv_req_i.ar_valid & ~rd_gate;
    mst_req_o.aw_valid = slv_req_i.aw_valid & ~wr_gate;
    slv_rsp_o          = mst_rsp_i;
    slv_rsp_o.ar_ready = mst_rsp_i.ar_ready & ~rd_gate;
    slv_rsp_o.aw_ready = mst_rsp_i.aw_ready & ~wr_gate;
  end

  assign rd_push = mst_req_o.ar_valid & mst_rsp_i.ar_ready;
  assign wr_push = mst_req_o.aw_valid & mst_rsp_i.aw_ready;

  dma_addr_fifo #(.Depth(MaxRdTxns), .Width(AddrWidth)) u_rd_fifo (
    .clk_i, .rst_ni,
    .push_i (rd_push), .data_i (slv_req_i.ar.addr[AddrWidth-1:0]), .pop_i (rd_pop),
    .full_o (rd_full), .empty_o (rd_empty), .head_o (rd_head)
  );

  dma_addr_fifo #(.Depth(MaxWrTxns), .Width(AddrWidth)) u_wr_fifo (
    .clk_i, .rst_ni,
    .push_i (wr_push), .data_i (slv_req_i.aw.addr[AddrWidth-1:0]), .pop_i (wr_pop),
    .full_o (wr_full), .empty_o (wr_empty), .head_o (wr_head)
  );

  assign rd_err = r_hs & (mst_rsp_i.r.resp[1] | (mst_rsp_i.r.last & rd_empty));
  assign wr_err = b_hs & (mst_rsp_i.b.resp[1] | wr_empty);

  fault_info_t info_q, info_new;
  logic        fault_q, capture;
  logic [7:0]  cnt_q;
  logic [1:0]  err_num;
  logic [8:0]  cnt_sum;

  // Read path has priority when both channels error in the same cycle.
  always_comb begin
    info_new = '0;
    if (rd_err) begin
      info_new.addr  = rd_empty ? '0 : AXI_ADDR_W'(rd_head);
      info_new.is_wr = 1'b0;
      info_new.resp  = mst_rsp_i.r.resp;
      info_new.unexp = rd_empty;
    end else if (wr_err) begin
      info_new.addr  = wr_empty ? '0 : AXI_ADDR_W'(wr_head);
      info_new.is_wr = 1'b1;
      info_new.resp  = mst_rsp_i.b.resp;
      info_new.unexp = wr_empty;
    end
  end

  assign err_num = {1'b0, rd_err} + {1'b0, wr_err};
  assign cnt_sum = {1'b0, cnt_q} + {7'b0, err_num};
  assign capture = (rd_err | wr_err) & (~fault_q | clear_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fault_q <= 1'b0;
      info_q  <= '0;
      cnt_q   <= '0;
    end else begin
      if (capture) begin
        fault_q <= 1'b1;
        info_q  <= info_new;
      end else if (clear_i) begin
        fault_q <= 1'b0;
        info_q  <= '0;
      end
      if (clear_i)         cnt_q <= {6'b0, err_num};
      else if (cnt_sum[8]) cnt_q <= 8'hff;
      else                 cnt_q <= cnt_sum[7:0];
    end
  end

  assign fault_o       = fault_q;
  assign fault_addr_o  = info_q.addr[AddrWidth-1:0];
  assign fault_is_wr_o = info_q.is_wr;
  assign fault_resp_o  = info_q.resp;
  assign fault_unexp_o = info_q.unexp;
  assign fault_cnt_o   = cnt_q;
  assign busy_o        = ~rd_empty | ~wr_empty;

endmodule

// File: tb/tb_dma_axi_fault_monitor.sv
// Directed bench for dma_axi_fault_monitor with a burst-address scoreboard per channel.
module tb_dma_axi_fault_monitor;
  import dma_fault_mon_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        clear_i = 1'b0;
  axi_req_t    slv_req_i, mst_req_o;
  axi_rsp_t    slv_rsp_o, mst_rsp_i;
  logic        fault_o, fault_is_wr_o, fault_unexp_o, busy_o;
  logic [63:0] fault_addr_o;
  logic [1:0]  fault_resp_o;
  logic [7:0]  fault_cnt_o;

  logic [63:0] rd_exp_q[$];
  logic [63:0] wr_exp_q[$];
  logic [63:0] exp_addr;
  int          n_vec = 0;
  int          n_err = 0;

  dma_axi_fault_monitor dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .slv_req_i     (slv_req_i),
    .slv_rsp_o     (slv_rsp_o),
    .mst_req_o     (mst_req_o),
    .mst_rsp_i     (mst_rsp_i),
    .clear_i       (clear_i),
    .fault_o       (fault_o),
    .fault_addr_o  (fault_addr_o),
    .fault_is_wr_o (fault_is_wr_o),
    .fault_resp_o  (fault_resp_o),
    .fault_unexp_o (fault_unexp_o),
    .fault_cnt_o   (fault_cnt_o),
    .busy_o        (busy_o)
  );

  // clock / watchdog
  always #5 clk_i = ~clk_i;

  initial begin
    #2ms;
    $display("FAIL watchdog: observed no finish, expected finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_ar(input logic [63:0] addr);
    slv_req_i.ar_valid = 1'b1;
    slv_req_i.ar.addr  = addr;
    tick();
    slv_req_i.ar_valid = 1'b0;
    rd_exp_q.push_back(addr);
  endtask

  task automatic drive_aw(input logic [63:0] addr);
    slv_req_i.aw_valid = 1'b1;
    slv_req_i.aw.addr  = addr;
    tick();
    slv_req_i.aw_valid = 1'b0;
    wr_exp_q.push_back(addr);
  endtask

  // One R beat; a last beat retires the oldest tracked read burst in the scoreboard.
  task automatic drive_r(input logic last, input logic [1:0] resp);
    mst_rsp_i.r_valid = 1'b1;
    mst_rsp_i.r.last  = last;
    mst_rsp_i.r.resp  = resp;
    tick();
    mst_rsp_i.r_valid = 1'b0;
    mst_rsp_i.r.last  = 1'b0;
    if (last && rd_exp_q.size() > 0) exp_addr = rd_exp_q.pop_front();
  endtask

  task automatic drive_b(input logic [1:0] resp);
    mst_rsp_i.b_valid = 1'b1;
    mst_rsp_i.b.resp  = resp;
    tick();
    mst_rsp_i.b_valid = 1'b0;
    exp_addr = (wr_exp_q.size() > 0) ? wr_exp_q.pop_front() : 64'h0;
  endtask

  task automatic pulse_clear();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
  endtask

  initial begin
    slv_req_i          = '0;
    slv_req_i.r_ready  = 1'b1;
    slv_req_i.b_ready  = 1'b1;
    mst_rsp_i          = '0;
    mst_rsp_i.ar_ready = 1'b1;
    mst_rsp_i.aw_ready = 1'b1;
    exp_addr           = '0;

    // reset state
    #12;
    check("rst_fault", 64'(fault_o), 64'(0));
    check("rst_busy", 64'(busy_o), 64'(0));
    check("rst_cnt", 64'(fault_cnt_o), 64'(0));
    check("rst_addr", fault_addr_o, 64'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();

    // single read burst, 4 OKAY beats
    slv_req_i.ar_valid = 1'b1;
    slv_req_i.ar.addr  = 64'h1000;
    @(negedge clk_i);
    check("ar_passthru", 64'(mst_req_o.ar_valid), 64'(1));
    tick();
    slv_req_i.ar_valid = 1'b0;
    rd_exp_q.push_back(64'h1000);
    check("busy_after_ar", 64'(busy_o), 64'(1));
    for (int i = 0; i < 3; i++) drive_r(1'b0, AXI_RESP_OKAY);
    check("busy_mid_burst", 64'(busy_o), 64'(1));
    drive_r(1'b1, AXI_RESP_OKAY);
    check("busy_after_last", 64'(busy_o), 64'(0));
    check("okay_fault", 64'(fault_o), 64'(0));
    check("okay_cnt", 64'(fault_cnt_o), 64'(0));

    // outstanding read cap
    for (int i = 0; i < 8; i++) drive_ar(64'h5000 + 64'(i) * 64'h40);
    slv_req_i.ar_valid = 1'b1;
    slv_req_i.ar.addr  = 64'h5900;
    @(negedge clk_i);
    check("cap_ar_ready", 64'(slv_rsp_o.ar_ready), 64'(0));
    check("cap_mst_valid", 64'(mst_req_o.ar_valid), 64'(0));
    mst_rsp_i.r_valid = 1'b1;
    mst_rsp_i.r.last  = 1'b1;
    mst_rsp_i.r.resp  = AXI_RESP_OKAY;
    #1;
    check("pop_ar_ready", 64'(slv_rsp_o.ar_ready), 64'(1));
    check("pop_mst_valid", 64'(mst_req_o.ar_valid), 64'(1));
    tick();
    slv_req_i.ar_valid = 1'b0;
    mst_rsp_i.r_valid  = 1'b0;
    mst_rsp_i.r.last   = 1'b0;
    exp_addr = rd_exp_q.pop_front();
    rd_exp_q.push_back(64'h5900);
    for (int i = 0; i < 8; i++) drive_r(1'b1, AXI_RESP_OKAY);
    check("cap_drained", 64'(busy_o), 64'(0));
    check("cap_no_fault", 64'(fault_o), 64'(0));

    // write path error
    drive_aw(64'h2000);
    drive_aw(64'h3000);
    drive_b(AXI_RESP_OKAY);
    check("b_okay_fault", 64'(fault_o), 64'(0));
    drive_b(AXI_RESP_SLVERR);
    check("wr_fault", 64'(fault_o), 64'(1));
    check("wr_addr", fault_addr_o, exp_addr);
    check("wr_is_wr", 64'(fault_is_wr_o), 64'(1));
    check("wr_resp", 64'(fault_resp_o), 64'(AXI_RESP_SLVERR));
    check("wr_cnt", 64'(fault_cnt_o), 64'(1));
    check("wr_unexp", 64'(fault_unexp_o), 64'(0));

    // clear, then simultaneous R DECERR and B SLVERR
    pulse_clear();
    check("clr_fault", 64'(fault_o), 64'(0));
    check("clr_cnt", 64'(fault_cnt_o), 64'(0));
    drive_ar(64'h4000);
    drive_aw(64'h4800);
    mst_rsp_i.b_valid = 1'b1;
    mst_rsp_i.b.resp  = AXI_RESP_SLVERR;
    drive_r(1'b1, AXI_RESP_DECERR);
    mst_rsp_i.b_valid = 1'b0;
    void'(wr_exp_q.pop_front());
    check("dual_is_wr", 64'(fault_is_wr_o), 64'(0));
    check("dual_addr", fault_addr_o, exp_addr);
    check("dual_resp", 64'(fault_resp_o), 64'(AXI_RESP_DECERR));
    check("dual_cnt", 64'(fault_cnt_o), 64'(2));

    // clear coinciding with a new error
    drive_aw(64'h6000);
    clear_i = 1'b1;
    drive_b(AXI_RESP_DECERR);
    clear_i = 1'b0;
    check("clrerr_fault", 64'(fault_o), 64'(1));
    check("clrerr_addr", fault_addr_o, exp_addr);
    check("clrerr_is_wr", 64'(fault_is_wr_o), 64'(1));
    check("clrerr_resp", 64'(fault_resp_o), 64'(AXI_RESP_DECERR));
    check("clrerr_cnt", 64'(fault_cnt_o), 64'(1));
    for (int i = 0; i < 300; i++) drive_b(2'($urandom_range(2, 3)));
    check("sat_cnt", 64'(fault_cnt_o), 64'(255));
    check("sat_keep_addr", fault_addr_o, 64'h6000);
    check("sat_keep_unexp", 64'(fault_unexp_o), 64'(0));

    // unexpected B with empty write FIFO
    pulse_clear();
    drive_b(AXI_RESP_OKAY);
    check("unexp_fault", 64'(fault_o), 64'(1));
    check("unexp_flag", 64'(fault_unexp_o), 64'(1));
    check("unexp_addr", fault_addr_o, 64'h0);
    check("unexp_cnt", 64'(fault_cnt_o), 64'(1));
    check("unexp_busy", 64'(busy_o), 64'(0));
    drive_aw(64'h7000);
    check("post_unexp_busy", 64'(busy_o), 64'(1));
    drive_b(AXI_RESP_OKAY);
    check("no_underflow", 64'(busy_o), 64'(0));

    // asynchronous reset mid-burst
    pulse_clear();
    drive_ar(64'h8000);
    drive_r(1'b0, AXI_RESP_SLVERR);
    check("mid_fault", 64'(fault_o), 64'(1));
    check("mid_addr", fault_addr_o, 64'h8000);
    @(negedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    check("arst_fault", 64'(fault_o), 64'(0));
    check("arst_busy", 64'(busy_o), 64'(0));
    check("arst_cnt", 64'(fault_cnt_o), 64'(0));
    check("arst_addr", fault_addr_o, 64'h0);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
